sc_ir_fetch: RTL and testbench

Instruction fetch sequencer feeding the instruction register of the ARC datapath. On a fetch request from the control unit it reads one 32-bit word from program memory at the current PC over a read/ready handshake. It drives the word onto the IR data bus with a one-cycle write strobe, then advances PC by 4. It also accepts branch-target loads into PC and aborts stalled reads with a timeout error.

---
 rtl/sc_ir_fetch.sv | 72 +++++++
 tb/tb_sc_ir_fetch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sc_ir_fetch.sv
// sc_ir_fetch: fetches one program word per Start over a read/ready handshake,
// strobes it into the IR, advances PC by 4, and aborts stalled reads with a timeout.
module sc_ir_fetch #(
  parameter int DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] PC_RESET_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     SC_IRFetch_CLOCK_50,
  input  logic                     SC_IRFetch_Reset_InLow,
  input  logic                     SC_IRFetch_Start_InHigh,
  input  logic                     SC_IRFetch_PCLoad_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SC_IRFetch_PCTarget_In,
  output logic [DATAWIDTH_BUS-1:0] SC_IRFetch_MemAddr_Out,
  output logic                     SC_IRFetch_MemRead_OutHigh,
  input  logic                     SC_IRFetch_MemReady_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SC_IRFetch_MemData_In,
  output logic [DATAWIDTH_BUS-1:0] SC_IRFetch_IRData_Out,
  output logic                     SC_IRFetch_IRWrite_OutHigh,
  output logic [DATAWIDTH_BUS-1:0] SC_IRFetch_PC_Out,
  output logic                     SC_IRFetch_Busy_OutHigh,
  output logic                     SC_IRFetch_Done_OutHigh,
  output logic                     SC_IRFetch_Error_OutHigh
);
  typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t state, state_next;
  logic [DATAWIDTH_BUS-1:0] pc, ir;
  logic [7:0] cnt;
  logic err;
  always_ff @(posedge SC_IRFetch_CLOCK_50 or negedge SC_IRFetch_Reset_InLow)
    if (!SC_IRFetch_Reset_InLow) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SC_IRFetch_Start_InHigh ? REQ : IDLE;
      REQ:     state_next = SC_IRFetch_MemReady_InHigh ? LOAD : (cnt == CNT_LAST ? IDLE : REQ);
      default: state_next = IDLE;
    endcase
  end
  // Strobes decode straight from state so reset drops them without a clock edge.
  always_comb begin
    SC_IRFetch_MemRead_OutHigh = state == REQ;
    SC_IRFetch_IRWrite_OutHigh = state == LOAD;
    SC_IRFetch_Done_OutHigh    = state == LOAD;
    SC_IRFetch_Busy_OutHigh    = state != IDLE;
  end
  always_ff @(posedge SC_IRFetch_CLOCK_50 or negedge SC_IRFetch_Reset_InLow)
    if (!SC_IRFetch_Reset_InLow) begin
      pc  <= PC_RESET_ADDR;
      ir  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && SC_IRFetch_PCLoad_InHigh)
        pc <= {SC_IRFetch_PCTarget_In[DATAWIDTH_BUS-1:2], 2'b00};
      if (state == IDLE && SC_IRFetch_Start_InHigh) begin
        err <= 1'b0;
        cnt <= '0;
      end
      if (state == REQ) begin
        if (SC_IRFetch_MemReady_InHigh) ir <= SC_IRFetch_MemData_In;
        else if (cnt == CNT_LAST) err <= 1'b1;
        else cnt <= cnt + 8'd1;
      end
      if (state == LOAD) pc <= pc + DATAWIDTH_BUS'(4);
    end
  assign SC_IRFetch_MemAddr_Out   = pc;
  assign SC_IRFetch_PC_Out        = pc;
  assign SC_IRFetch_IRData_Out    = ir;
  assign SC_IRFetch_Error_OutHigh = err;
endmodule

// File: tb/tb_sc_ir_fetch.sv
// tb_sc_ir_fetch: transaction-level model of the fetch sequencer checked every cycle,
// plus directed pins for reset, back-to-back, target load, wrap, timeout and async reset.
module tb_sc_ir_fetch;
  localparam int T = 6;
  localparam logic [31:0] RST_PC = 32'h0;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, pcload = 1'b0, ready = 1'b0;
  logic [31:0] target = '0, mdata = '0;
  logic [31:0] memaddr, irdata, pc;
  logic memread, irwrite, busy, done, err;
  int total = 0, bad = 0, busy_run = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_pc = RST_PC, m_ir = '0, saved_ir;
  logic m_err = 1'b0;
  int m_phase = 0;
  sc_ir_fetch #(.DATAWIDTH_BUS(32), .PC_RESET_ADDR(RST_PC), .TIMEOUT_CYCLES(T)) dut (
    .SC_IRFetch_CLOCK_50(clk), .SC_IRFetch_Reset_InLow(rst_n),
    .SC_IRFetch_Start_InHigh(start), .SC_IRFetch_PCLoad_InHigh(pcload),
    .SC_IRFetch_PCTarget_In(target), .SC_IRFetch_MemAddr_Out(memaddr),
    .SC_IRFetch_MemRead_OutHigh(memread), .SC_IRFetch_MemReady_InHigh(ready),
    .SC_IRFetch_MemData_In(mdata), .SC_IRFetch_IRData_Out(irdata),
    .SC_IRFetch_IRWrite_OutHigh(irwrite), .SC_IRFetch_PC_Out(pc),
    .SC_IRFetch_Busy_OutHigh(busy), .SC_IRFetch_Done_OutHigh(done),
    .SC_IRFetch_Error_OutHigh(err));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_memread"}, 32'(memread), 0);
    chk({tag, "_irwrite"}, 32'(irwrite), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_addr"}, memaddr, RST_PC);
    chk({tag, "_ir"}, irdata, 0);
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("addr", memaddr, m_pc);
    chk("pc", pc, m_pc);
    chk("ir", irdata, m_ir);
    chk("err", 32'(err), 32'(m_err));
    chk("memread", 32'(memread), 32'(m_phase == 1));
    chk("irwrite", 32'(irwrite), 32'(m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    if (busy) busy_run++;
  end
  task automatic idle_cycle(input bit ld, input logic [31:0] tgt);
    start = 0; pcload = ld; target = tgt; ready = 1'($urandom); mdata = $urandom;
    @(posedge clk); #1;
    if (ld) m_pc = tgt & ~32'h3;
    pcload = 0; ready = 0;
  endtask
  // One fetch transaction: d = REQ cycles before ready (d >= T means it times out).
  task automatic fetch(input bit ld, input logic [31:0] tgt, input int d,
                       input logic [31:0] data, input bit noise);
    start = 1; pcload = ld; target = tgt; ready = 1'($urandom); mdata = $urandom;
    @(posedge clk); #1;
    start = 0; pcload = 0;
    if (ld) m_pc = tgt & ~32'h3;
    m_err = 0; m_phase = 1; busy_run = 0;
    for (int i = 0; i < T; i++) begin
      ready = (i == d); mdata = (i == d) ? data : $urandom;
      if (noise) begin start = 1'($urandom); pcload = 1'($urandom); target = $urandom; end
      @(posedge clk); #1;
      start = 0; pcload = 0;
      if (i == d) begin
        m_ir = data; m_phase = 2;
        ready = 1'($urandom); mdata = $urandom;
        if (noise) begin start = 1'($urandom); pcload = 1'($urandom); target = $urandom; end
        @(posedge clk); #1;
        start = 0; pcload = 0; ready = 0;
        m_pc = m_pc + 32'd4; m_phase = 0;
        return;
      end
    end
    m_err = 1; m_phase = 0; ready = 0;
  endtask
  initial begin
    #1 rst_n = 0;
    #2 chk_reset_vals("por");
    @(posedge clk); #1 rst_n = 1;
    chk_en = 1;
    fetch(0, 0, 0, 32'h8A00_4002, 0);
    chk("pin_first_ir", irdata, 32'h8A00_4002);
    chk("pin_first_pc", pc, 32'h4);
    chk("pin_first_busy", 32'(busy_run), 2);
    fetch(1, 0, 0, 32'h1111_0000, 0);
    chk("pin_b2b0", 32'(busy_run), 2);
    fetch(0, 0, 2, 32'h2222_0004, 0);
    chk("pin_b2b2", 32'(busy_run), 4);
    fetch(0, 0, 5, 32'h3333_0008, 0);
    chk("pin_b2b5", 32'(busy_run), 7);
    chk("pin_b2b_pc", pc, 32'hC);
    fetch(1, 32'h0000_1003, 1, 32'hCAFE_F00D, 1);
    chk("pin_load_pc", pc, 32'h0000_1004);
    fetch(1, 32'hFFFF_FFFC, 0, 32'h0BAD_BEEF, 0);
    chk("pin_wrap_pc", pc, 32'h0);
    saved_ir = irdata;
    fetch(0, 0, 99, 32'hDEAD_DEAD, 1);
    chk("pin_to_err", 32'(err), 1);
    chk("pin_to_busy", 32'(busy_run), T);
    chk("pin_to_pc", pc, 32'h0);
    chk("pin_to_ir", irdata, 32'h0BAD_BEEF);
    idle_cycle(0, 0);
    fetch(0, 0, 1, 32'h5555_AAAA, 0);
    chk("pin_to_clear", 32'(err), 0);
    chk("pin_to_after_pc", pc, 32'h4);
    for (int n = 0; n < 300; n++) begin
      automatic int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idle_cycle(1'($urandom_range(0, 3) == 0), $urandom);
      fetch(1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, T + 2), $urandom, 1'($urandom));
    end
    fetch(1, 32'h0000_2000, 0, 32'h1234_5678, 0);
    start = 1;
    @(posedge clk); #1 start = 0; m_phase = 1; m_err = 0;
    #2 rst_n = 0;
    #1 chk_reset_vals("rst_req");
    m_pc = RST_PC; m_ir = 0; m_err = 0; m_phase = 0;
    @(posedge clk); #1 rst_n = 1;
    start = 1; ready = 1; mdata = 32'h7777_8888;
    @(posedge clk); #1 start = 0; m_phase = 1;
    @(posedge clk); #1 ready = 0; m_phase = 2; m_ir = 32'h7777_8888;
    #2 rst_n = 0;
    #1 chk_reset_vals("rst_load");
    m_pc = RST_PC; m_ir = 0; m_err = 0; m_phase = 0;
    @(posedge clk); #1 rst_n = 1;
    fetch(0, 0, 0, 32'h9999_0000, 0);
    chk("pin_post_rst_pc", pc, RST_PC + 32'd4);
    chk("pin_post_rst_ir", irdata, 32'h9999_0000);
    @(posedge clk); #1 chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
